// File: rtl/wb_arbiter_pkg.sv
// Shared Wishbone bus types and arbiter constants used by the arbiter and its
// round-robin picker.
package wb_arbiter_pkg;

  localparam int WB_AW           = 32;
  localparam int WB_DW           = 32;
  localparam int WB_SW           = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
  } iWishbone_Ctrl;

  typedef struct packed {
    logic             ack;
    logic [WB_DW-1:0] dat;
  } iWishbone_Peri;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  // Saturating 8-bit increment for event counters
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after ptr, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  logic [N-1:0] rot_s;
  logic [N-1:0] first_s;

  // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back
  assign rot_s   = (req >> ptr) | (req << (N - int'(ptr)));
  assign first_s = rot_s & (~rot_s + N'(1));
  assign gnt     = (first_s << ptr) | (first_s >> (N - int'(ptr)));

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter letting N Wishbone controllers share one peripheral bus,
// with a per-strobe ack watchdog that synthesizes an aborting ack.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  iWishbone_Ctrl wb_c_in  [N],
  output iWishbone_Peri wb_p_out [N],
  output iWishbone_Ctrl wb_c,
  input  iWishbone_Peri wb_p,
  output logic [N-1:0]  grant,
  output logic [7:0]    timeout_cnt
);

  localparam int PTR_W = $clog2(N);
  // Abort fires on the stalled cycle that would take the count to TIMEOUT
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  arb_state_e       state_r;
  logic [N-1:0]     grant_r;
  logic [PTR_W-1:0] owner_r;
  logic [PTR_W-1:0] rr_ptr_r;
  logic [7:0]       wdog_r;
  logic [7:0]       tcnt_r;

  logic [N-1:0]     req_s;
  logic [N-1:0]     pick_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic [PTR_W-1:0] next_ptr_s;
  iWishbone_Ctrl    own_c_s;

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) begin
        idx = PTR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Collect the cyc lines into a request vector
  always_comb begin
    req_s = '0;
    for (int i = 0; i < N; i++) begin
      req_s[i] = wb_c_in[i].cyc;
    end
  end

  rr_pick #(.N(N)) u_rr_pick (
    .req (req_s),
    .ptr (rr_ptr_r),
    .gnt (pick_s)
  );

  assign pick_idx_s = onehot_idx(pick_s);
  assign next_ptr_s = (pick_idx_s == PTR_W'(N - 1)) ? '0 : pick_idx_s + PTR_W'(1);
  assign own_c_s    = wb_c_in[owner_r];

  // Arbitration FSM, watchdog and abort counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      grant_r  <= '0;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      wdog_r   <= 8'd0;
      tcnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wdog_r <= 8'd0;
          if (|req_s) begin
            state_r  <= ST_OWNED;
            grant_r  <= pick_s;
            owner_r  <= pick_idx_s;
            rr_ptr_r <= next_ptr_s;
          end else begin
            grant_r <= '0;
          end
        end
        ST_OWNED: begin
          if (!own_c_s.cyc) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            wdog_r  <= 8'd0;
          end else if (!own_c_s.stb || wb_p.ack) begin
            wdog_r <= 8'd0;
          end else if (wdog_r == WDOG_LAST) begin
            state_r <= ST_ABORT;
            wdog_r  <= 8'd0;
            tcnt_r  <= sat_inc8(tcnt_r);
          end else begin
            wdog_r <= wdog_r + 8'd1;
          end
        end
        ST_ABORT: begin
          wdog_r <= 8'd0;
          if (own_c_s.cyc) begin
            state_r <= ST_OWNED;
          end else begin
            state_r <= ST_IDLE;
            grant_r <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          wdog_r  <= 8'd0;
        end
      endcase
    end
  end

  // Shared bus follows the owner only while it legitimately holds the bus
  always_comb begin
    wb_c = '0;
    if (state_r == ST_OWNED) begin
      wb_c = own_c_s;
    end else begin
      wb_c = '0;
    end
  end

  // Route the response to the owner; an abort substitutes an empty ack
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wb_p_out[i] = '0;
      if ((state_r == ST_OWNED) && (owner_r == PTR_W'(i))) begin
        wb_p_out[i] = wb_p;
      end else if ((state_r == ST_ABORT) && (owner_r == PTR_W'(i))) begin
        wb_p_out[i].ack = 1'b1;
        wb_p_out[i].dat = '0;
      end else begin
        wb_p_out[i] = '0;
      end
    end
  end

  assign grant       = grant_r;
  assign timeout_cnt = tcnt_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a cycle-level
// behavioural model of ownership, round-robin order and the ack watchdog.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  iWishbone_Ctrl c_in  [N];
  iWishbone_Peri p_out [N];
  iWishbone_Ctrl c_bus;
  iWishbone_Peri p_bus;
  logic [N-1:0]  grant;
  logic [7:0]    tcnt;

  int tests = 0;
  int fails = 0;

  // Model: current owner (-1 none), abort cycle flag, consecutive stalls,
  // first index to consider next, abort count
  int m_owner;
  bit m_abort;
  int m_stall;
  int m_next;
  int m_tcnt;

  logic [N-1:0] alt_seq [4] = '{3'b001, 3'b010, 3'b001, 3'b010};

  wb_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_c_in     (c_in),
    .wb_p_out    (p_out),
    .wb_c        (c_bus),
    .wb_p        (p_bus),
    .grant       (grant),
    .timeout_cnt (tcnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_abort = 1'b0;
    m_stall = 0;
    m_next  = 0;
    m_tcnt  = 0;
  endtask

  task automatic model_edge();
    if (m_abort) begin
      m_abort = 1'b0;
      m_stall = 0;
      if (!c_in[m_owner].cyc) m_owner = -1;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_next + k) % N;
        if (m_owner < 0 && c_in[c].cyc) m_owner = c;
      end
      if (m_owner >= 0) begin
        m_next  = (m_owner + 1) % N;
        m_stall = 0;
      end
    end else if (!c_in[m_owner].cyc) begin
      m_owner = -1;
    end else if (c_in[m_owner].stb && !p_bus.ack) begin
      m_stall++;
      if (m_stall == TO) begin
        m_abort = 1'b1;
        m_stall = 0;
        if (m_tcnt < 255) m_tcnt++;
      end
    end else begin
      m_stall = 0;
    end
  endtask

  task automatic check_outputs();
    iWishbone_Ctrl e_c;
    iWishbone_Peri e_p;
    logic [N-1:0]  e_g;
    e_c = '0;
    e_g = '0;
    if (m_owner >= 0) begin
      e_g = N'(1) << m_owner;
      if (!m_abort) e_c = c_in[m_owner];
    end
    check_eq("grant", 96'(grant), 96'(e_g));
    check_eq("timeout_cnt", 96'(tcnt), 96'(m_tcnt));
    check_eq("wb_c", 96'(c_bus), 96'(e_c));
    for (int i = 0; i < N; i++) begin
      e_p = '0;
      if (i == m_owner) begin
        if (m_abort) e_p.ack = 1'b1;
        else         e_p = p_bus;
      end
      check_eq($sformatf("wb_p_out%0d", i), 96'(p_out[i]), 96'(e_p));
    end
  endtask

  task automatic settle();
    #2;
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) c_in[i] = '0;
    p_bus = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    for (int w = 0; w < 6 && grant == '0; w++) tick();
  endtask

  task automatic request(input int i);
    c_in[i].cyc = 1'b1;
    c_in[i].stb = 1'b1;
    c_in[i].adr = $urandom;
    c_in[i].sel = 4'hF;
  endtask

  initial begin
    int own;
    model_reset();
    idle_inputs();
    do_reset();

    // Single read by ctrl0, peripheral answers 0xA5 on the third owned cycle
    request(0);
    tick();
    check_eq("grant_latency", 96'(grant), 96'(3'b001));
    tick();
    tick();
    p_bus.ack = 1'b1;
    p_bus.dat = 32'hA5;
    settle();
    check_eq("read_data", 96'({p_out[0].ack, p_out[0].dat}), 96'({1'b1, 32'hA5}));
    check_eq("nonowner_zero", 96'(p_out[1]), 96'(0));
    advance();
    idle_inputs();
    tick();
    tick();

    // Two continuous requesters alternate, one idle cycle in between
    do_reset();
    request(0);
    request(1);
    for (int t = 0; t < 4; t++) begin
      wait_grant();
      check_eq("alt_grant", 96'(grant), 96'(alt_seq[t]));
      own = grant[1] ? 1 : 0;
      p_bus.ack = 1'b1;
      p_bus.dat = $urandom;
      tick();
      p_bus = '0;
      c_in[own].cyc = 1'b0;
      c_in[own].stb = 1'b0;
      tick();
      check_eq("alt_idle_gap", 96'(grant), 96'(0));
      request(own);
    end
    idle_inputs();
    tick();
    tick();

    // Watchdog abort for ctrl1 with no ack ever
    do_reset();
    request(1);
    wait_grant();
    check_eq("to_grant", 96'(grant), 96'(3'b010));
    for (int s = 0; s < TO; s++) tick();
    settle();
    check_eq("abort_ack", 96'({p_out[1].ack, p_out[1].dat}), 96'({1'b1, 32'h0}));
    check_eq("abort_cyc", 96'(c_bus.cyc), 96'(0));
    check_eq("abort_cnt", 96'(tcnt), 96'(1));
    advance();
    idle_inputs();
    tick();
    tick();

    // Ack on the same cycle the watchdog would fire wins
    do_reset();
    request(0);
    wait_grant();
    for (int s = 0; s < TO - 1; s++) tick();
    p_bus.ack = 1'b1;
    p_bus.dat = 32'h5A;
    settle();
    check_eq("race_ack", 96'({p_out[0].ack, p_out[0].dat}), 96'({1'b1, 32'h5A}));
    advance();
    idle_inputs();
    settle();
    check_eq("race_no_abort", 96'(p_out[0].ack), 96'(0));
    check_eq("race_cnt", 96'(tcnt), 96'(0));
    advance();
    tick();

    // Reset mid-transaction with a second requester waiting
    do_reset();
    request(0);
    request(1);
    wait_grant();
    tick();
    rst = 1'b1;
    #1;
    check_eq("rst_cyc_drop", 96'(c_bus.cyc), 96'(0));
    check_eq("rst_grant", 96'(grant), 96'(0));
    check_eq("rst_no_ack", 96'(p_out[0]), 96'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_grant();
    check_eq("post_rst_grant", 96'(grant), 96'(3'b001));
    idle_inputs();
    tick();
    tick();

    // ctrl2 keeps ownership across three strobes while ctrl0 waits
    do_reset();
    request(2);
    wait_grant();
    check_eq("hold_first", 96'(grant), 96'(3'b100));
    request(0);
    for (int s = 0; s < 3; s++) begin
      p_bus.ack = 1'b1;
      settle();
      check_eq("hold_grant", 96'(grant), 96'(3'b100));
      advance();
      p_bus.ack = 1'b0;
      c_in[2].stb = 1'b0;
      tick();
      c_in[2].stb = 1'b1;
    end
    c_in[2].cyc = 1'b0;
    c_in[2].stb = 1'b0;
    tick();
    tick();
    check_eq("handover", 96'(grant), 96'(3'b001));
    idle_inputs();
    tick();

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(99) < 12) c_in[i].cyc = ~c_in[i].cyc;
        c_in[i].stb = c_in[i].cyc & ($urandom_range(99) < 70);
        c_in[i].we  = 1'($urandom_range(1));
        c_in[i].adr = $urandom;
        c_in[i].dat = $urandom;
        c_in[i].sel = 4'($urandom_range(15));
      end
      p_bus.ack = ($urandom_range(99) < 25);
      p_bus.dat = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
